// File: rtl/rv32i_img_cmd_master.sv
// rv32i_img_cmd_master: CPU-side initiator for the custom IMG R-type instructions.
// A rectangular block command (write, read or status) is expanded into a raster
// sequence of single-pixel IM_WR / IM_RD / IM_STAT instructions, and the
// responder's register writebacks are collected into a readback stream or the
// status word.
// Optional build macro: IMG_CMD_MASTER_TIMEOUT_EN adds a writeback timeout that
// ends the command with err after TIMEOUT cycles in WAIT.
module rv32i_img_cmd_master #(
    parameter int         DATA_W  = 32,
    parameter logic [4:0] RD_REG  = 5'd5,
    parameter int         TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [15:0]       cmd_row0,
    input  logic [15:0]       cmd_col0,
    input  logic [15:0]       cmd_h,
    input  logic [15:0]       cmd_w,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rdo_valid,
    input  logic              rdo_ready,
    output logic [DATA_W-1:0] rdo_data,
    output logic [31:0]       stat_word,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [31:0]       rs1_val,
    output logic [31:0]       rs2_val,
    output logic [4:0]        rd_addr,
    input  logic              rd_we,
    input  logic [4:0]        rd_waddr,
    input  logic [31:0]       rd_wdata
);

    // The pixel travels in a 32-bit register operand, so any other width is a build error.
    generate
        if (DATA_W != 32) begin : g_bad_data_w
            $error("rv32i_img_cmd_master: DATA_W must be 32");
        end
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("rv32i_img_cmd_master: TIMEOUT must be at least 1");
        end
    endgenerate

    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_STAT = 2'd2;
    localparam logic [1:0] OP_ILL  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH,
        S_FIN
    } state_t;

    state_t            r_state;
    logic [1:0]        r_op;
    logic [15:0]       r_row0;
    logic [15:0]       r_col0;
    logic [15:0]       r_h;
    logic [15:0]       r_w;
    logic [15:0]       r_row;
    logic [15:0]       r_col;
    logic              r_err;
    logic [31:0]       r_instr;
    logic [31:0]       r_stat;
    logic [DATA_W-1:0] r_rdo_data;

`ifdef IMG_CMD_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] r_wait_cnt;
`endif

    logic        w_is_wr;
    logic        w_instr_valid;
    logic        w_fire;
    logic        w_last_col;
    logic        w_last_pix;
    logic        w_wb_hit;
    logic [15:0] w_row_abs;
    logic [15:0] w_col_abs;

    assign w_is_wr    = (r_op == OP_WR);
    assign w_last_col = (r_col == r_w - 16'd1);
    assign w_last_pix = w_last_col && (r_row == r_h - 16'd1);
    assign w_wb_hit   = rd_we && (rd_waddr == RD_REG);
    assign w_row_abs  = r_row0 + r_row;
    assign w_col_abs  = r_col0 + r_col;

    // Writes pass the pixel stream straight through so a full-rate stream issues one pixel per cycle.
    assign w_instr_valid = (r_state == S_ISSUE) && (w_is_wr ? wr_valid : 1'b1);
    assign w_fire        = w_instr_valid && instr_ready;

    assign instr_valid = w_instr_valid;
    assign wr_ready    = (r_state == S_ISSUE) && w_is_wr && instr_ready;
    assign instr       = r_instr;
    assign rs1_val     = {w_row_abs, w_col_abs};
    assign rs2_val     = ((r_state == S_ISSUE) && w_is_wr) ? wr_data : 32'd0;
    assign rd_addr     = RD_REG;
    assign cmd_ready   = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign rdo_valid   = (r_state == S_PUSH);
    assign rdo_data    = r_rdo_data;
    assign stat_word   = r_stat;
    assign done        = (r_state == S_FIN);
    assign err         = (r_state == S_FIN) && r_err;

    // Command sequencer: latch the block, walk it in raster order, and collect writebacks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_op       <= OP_WR;
            r_row0     <= 16'd0;
            r_col0     <= 16'd0;
            r_h        <= 16'd0;
            r_w        <= 16'd0;
            r_row      <= 16'd0;
            r_col      <= 16'd0;
            r_err      <= 1'b0;
            r_instr    <= 32'd0;
            r_stat     <= 32'd0;
            r_rdo_data <= '0;
`ifdef IMG_CMD_MASTER_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op    <= cmd_op;
                        r_row0  <= cmd_row0;
                        r_col0  <= cmd_col0;
                        r_h     <= cmd_h;
                        r_w     <= cmd_w;
                        r_row   <= 16'd0;
                        r_col   <= 16'd0;
                        r_err   <= (cmd_op == OP_ILL);
                        r_instr <= {7'h06, 5'd11, 5'd10, {1'b0, cmd_op}, RD_REG, 7'h33};
                        if (cmd_op == OP_ILL) begin
                            r_state <= S_FIN;
                        end else if ((cmd_op != OP_STAT) && ((cmd_h == 16'd0) || (cmd_w == 16'd0))) begin
                            r_state <= S_FIN;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_fire) begin
                        if (w_is_wr) begin
                            if (w_last_col) begin
                                r_col <= 16'd0;
                                r_row <= r_row + 16'd1;
                            end else begin
                                r_col <= r_col + 16'd1;
                            end
                            if (w_last_pix) begin
                                r_state <= S_FIN;
                            end
                        end else begin
                            r_state <= S_WAIT;
`ifdef IMG_CMD_MASTER_TIMEOUT_EN
                            r_wait_cnt <= '0;
`endif
                        end
                    end
                end
                S_WAIT: begin
                    if (w_wb_hit) begin
                        if (r_op == OP_RD) begin
                            r_rdo_data <= rd_wdata;
                            r_state    <= S_PUSH;
                        end else begin
                            r_stat  <= rd_wdata;
                            r_state <= S_FIN;
                        end
`ifdef IMG_CMD_MASTER_TIMEOUT_EN
                    end else if (r_wait_cnt == TO_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TO_W'(1);
`endif
                    end
                end
                S_PUSH: begin
                    if (rdo_ready) begin
                        if (w_last_col) begin
                            r_col <= 16'd0;
                            r_row <= r_row + 16'd1;
                        end else begin
                            r_col <= r_col + 16'd1;
                        end
                        r_state <= w_last_pix ? S_FIN : S_ISSUE;
                    end
                end
                S_FIN: begin
                    r_err   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_img_cmd_master.sv
// tb_rv32i_img_cmd_master: directed, table-driven bench for rv32i_img_cmd_master.
// Build with IMG_CMD_MASTER_TIMEOUT_EN defined to also exercise the writeback timeout.
module tb_rv32i_img_cmd_master;

    localparam logic [4:0] TB_RD_REG = 5'd5;
`ifdef IMG_CMD_MASTER_TIMEOUT_EN
    localparam int TB_TIMEOUT = 8;
`else
    localparam int TB_TIMEOUT = 64;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_row0;
    logic [15:0] cmd_col0;
    logic [15:0] cmd_h;
    logic [15:0] cmd_w;
    logic        wr_valid;
    logic        wr_ready;
    logic [31:0] wr_data;
    logic        rdo_valid;
    logic        rdo_ready;
    logic [31:0] rdo_data;
    logic [31:0] stat_word;
    logic        busy;
    logic        done;
    logic        err;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [4:0]  rd_addr;
    logic        rd_we;
    logic [4:0]  rd_waddr;
    logic [31:0] rd_wdata;

    int testCount = 0;
    int failCount = 0;
    int fireCount = 0;
    int fires0;

    rv32i_img_cmd_master #(
        .DATA_W (32),
        .RD_REG (TB_RD_REG),
        .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_row0   (cmd_row0),
        .cmd_col0   (cmd_col0),
        .cmd_h      (cmd_h),
        .cmd_w      (cmd_w),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_data    (wr_data),
        .rdo_valid  (rdo_valid),
        .rdo_ready  (rdo_ready),
        .rdo_data   (rdo_data),
        .stat_word  (stat_word),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr      (instr),
        .rs1_val    (rs1_val),
        .rs2_val    (rs2_val),
        .rd_addr    (rd_addr),
        .rd_we      (rd_we),
        .rd_waddr   (rd_waddr),
        .rd_wdata   (rd_wdata)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    // Count every instruction handshake as the responder would see it.
    always @(posedge clk) begin
        if (!rst && instr_valid && instr_ready) fireCount++;
    end

    // Hard stop so a broken design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [31:0] data;
        int          stall;
        logic [31:0] rs1;
    } wrVec_t;

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] wbData;
        int          popStall;
        bit          stray;
    } rdVec_t;

    wrVec_t wrTbl[4];
    rdVec_t rdTbl[3];

    function automatic logic [31:0] encode(input logic [2:0] funct3);
        return {7'h06, 5'd11, 5'd10, funct3, TB_RD_REG, 7'h33};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present a command at the current negedge; returns at the negedge after acceptance.
    task automatic applyStimulus(input logic [1:0] op, input logic [15:0] row0, input logic [15:0] col0,
                                 input logic [15:0] h, input logic [15:0] w);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_row0  = row0;
        cmd_col0  = col0;
        cmd_h     = h;
        cmd_w     = w;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_row0 = 16'd0; cmd_col0 = 16'd0;
        cmd_h = 16'd0; cmd_w = 16'd0; wr_valid = 1'b0; wr_data = 32'd0; rdo_ready = 1'b0;
        instr_ready = 1'b0; rd_we = 1'b0; rd_waddr = 5'd0; rd_wdata = 32'd0;

        wrTbl[0] = '{32'h3F800000, 0, 32'h00030004};
        wrTbl[1] = '{32'h40000000, 2, 32'h00030005};
        wrTbl[2] = '{32'h40200000, 0, 32'h00040004};
        wrTbl[3] = '{32'h40400000, 0, 32'h00040005};

        rdTbl[0] = '{32'h0010FFFF, 32'hDEAD0001, 0, 1'b1};
        rdTbl[1] = '{32'h00100000, 32'h3F800000, 5, 1'b0};
        rdTbl[2] = '{32'h00100001, 32'hC0000000, 0, 1'b0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("reset cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset busy", {31'd0, busy}, 32'd0);
        checkOutput("reset instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("reset rdo_valid", {31'd0, rdo_valid}, 32'd0);
        checkOutput("reset done/err", {30'd0, done, err}, 32'd0);
        checkOutput("reset instr", instr, 32'd0);
        checkOutput("reset rs1_val", rs1_val, 32'd0);
        checkOutput("reset rs2_val", rs2_val, 32'd0);
        checkOutput("reset stat_word", stat_word, 32'd0);
        checkOutput("reset rd_addr", {27'd0, rd_addr}, {27'd0, TB_RD_REG});

        // Block write 2x2 at (3,4) with one back-pressure stall.
        @(negedge clk);
        fires0 = fireCount;
        applyStimulus(2'd0, 16'd3, 16'd4, 16'd2, 16'd2);
        for (int i = 0; i < 4; i++) begin
            for (int s = 0; s < wrTbl[i].stall; s++) begin
                wr_valid = 1'b1; wr_data = wrTbl[i].data; instr_ready = 1'b0;
                #1;
                checkOutput("wr stall wr_ready", {31'd0, wr_ready}, 32'd0);
                checkOutput("wr stall rs1_val", rs1_val, wrTbl[i].rs1);
                @(negedge clk);
            end
            wr_valid = 1'b1; wr_data = wrTbl[i].data; instr_ready = 1'b1;
            #1;
            checkOutput("wr instr_valid/wr_ready", {30'd0, instr_valid, wr_ready}, 32'd3);
            checkOutput("wr rs1_val", rs1_val, wrTbl[i].rs1);
            checkOutput("wr rs2_val", rs2_val, wrTbl[i].data);
            checkOutput("wr instr", instr, 32'h0CB502B3);
            checkOutput("wr done early", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        wr_valid = 1'b0;
        #1;
        checkOutput("wr done/err", {30'd0, done, err}, 32'd2);
        checkOutput("wr fire count", fireCount - fires0, 32'd4);
        @(negedge clk);
        #1;
        checkOutput("wr back to idle", {30'd0, cmd_ready, done}, 32'd2);

        // Block read 1x3 with column wrap, a stray writeback and a stalled pop.
        @(negedge clk);
        fires0 = fireCount;
        applyStimulus(2'd1, 16'h0010, 16'hFFFF, 16'd1, 16'd3);
        for (int i = 0; i < 3; i++) begin
            instr_ready = 1'b1;
            #1;
            checkOutput("rd instr_valid", {31'd0, instr_valid}, 32'd1);
            checkOutput("rd instr", instr, encode(3'b001));
            checkOutput("rd rs1_val", rs1_val, rdTbl[i].rs1);
            checkOutput("rd rs2_val", rs2_val, 32'd0);
            @(negedge clk);
            if (rdTbl[i].stray) begin
                rd_we = 1'b1; rd_waddr = 5'd7; rd_wdata = 32'h00000BAD;
            end
            #1;
            checkOutput("rd wait instr_valid", {31'd0, instr_valid}, 32'd0);
            @(negedge clk);
            rd_we = 1'b1; rd_waddr = TB_RD_REG; rd_wdata = rdTbl[i].wbData;
            #1;
            checkOutput("rd wait rdo_valid", {31'd0, rdo_valid}, 32'd0);
            @(negedge clk);
            rd_we = 1'b0; rdo_ready = 1'b0;
            for (int s = 0; s < rdTbl[i].popStall; s++) begin
                #1;
                checkOutput("rd held rdo_data", rdo_data, rdTbl[i].wbData);
                checkOutput("rd held valid/no issue", {30'd0, rdo_valid, instr_valid}, 32'd2);
                @(negedge clk);
            end
            rdo_ready = 1'b1;
            #1;
            checkOutput("rd rdo_valid", {31'd0, rdo_valid}, 32'd1);
            checkOutput("rd rdo_data", rdo_data, rdTbl[i].wbData);
            @(negedge clk);
            rdo_ready = 1'b0;
        end
        #1;
        checkOutput("rd done/err", {30'd0, done, err}, 32'd2);
        checkOutput("rd fire count", fireCount - fires0, 32'd3);

        // Status poll; a command offered while busy must not be taken.
        @(negedge clk);
        fires0 = fireCount;
        applyStimulus(2'd2, 16'd0, 16'd0, 16'd0, 16'd0);
        instr_ready = 1'b1;
        #1;
        checkOutput("stat instr", instr, encode(3'b010));
        checkOutput("stat instr_valid", {31'd0, instr_valid}, 32'd1);
        @(negedge clk);
        rd_we = 1'b1; rd_waddr = TB_RD_REG; rd_wdata = 32'h00000002;
        cmd_valid = 1'b1; cmd_op = 2'd3;
        #1;
        checkOutput("stat wait instr_valid", {31'd0, instr_valid}, 32'd0);
        @(negedge clk);
        rd_we = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0;
        #1;
        checkOutput("stat done/err", {30'd0, done, err}, 32'd2);
        checkOutput("stat stat_word", stat_word, 32'h00000002);
        checkOutput("stat fire count", fireCount - fires0, 32'd1);
        @(negedge clk);
        #1;
        checkOutput("stat busy cmd ignored", {30'd0, busy, done}, 32'd0);

        // Illegal op: immediate done with err, nothing issued.
        @(negedge clk);
        fires0 = fireCount;
        applyStimulus(2'd3, 16'd1, 16'd1, 16'd1, 16'd1);
        #1;
        checkOutput("ill instr_valid", {31'd0, instr_valid}, 32'd0);
        checkOutput("ill done/err", {30'd0, done, err}, 32'd3);
        @(negedge clk);
        #1;
        checkOutput("ill idle", {29'd0, cmd_ready, done, err}, 32'd4);
        checkOutput("ill fire count", fireCount - fires0, 32'd0);

        // Empty write (w=0): done without err, no pixel consumed.
        @(negedge clk);
        fires0 = fireCount;
        wr_valid = 1'b1; wr_data = 32'h12345678;
        applyStimulus(2'd0, 16'd1, 16'd1, 16'd5, 16'd0);
        #1;
        checkOutput("w0 instr_valid/wr_ready", {30'd0, instr_valid, wr_ready}, 32'd0);
        checkOutput("w0 done/err", {30'd0, done, err}, 32'd2);
        @(negedge clk);
        wr_valid = 1'b0;
        #1;
        checkOutput("w0 idle", {31'd0, cmd_ready}, 32'd1);
        checkOutput("w0 fire count", fireCount - fires0, 32'd0);

`ifdef IMG_CMD_MASTER_TIMEOUT_EN
        // Read with no writeback: timeout after TIMEOUT cycles in WAIT.
        @(negedge clk);
        instr_ready = 1'b1;
        applyStimulus(2'd1, 16'd0, 16'd0, 16'd1, 16'd1);
        #1;
        checkOutput("to instr_valid", {31'd0, instr_valid}, 32'd1);
        @(negedge clk);
        for (int k = 0; k < TB_TIMEOUT; k++) begin
            #1;
            checkOutput("to waiting done", {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        #1;
        checkOutput("to done/err", {30'd0, done, err}, 32'd3);
        checkOutput("to rdo_valid", {31'd0, rdo_valid}, 32'd0);
        checkOutput("to stat_word kept", stat_word, 32'h00000002);
        @(negedge clk);
        #1;
        checkOutput("to idle", {31'd0, busy}, 32'd0);
`endif

        // Reset while a readback pixel waits in PUSH.
        @(negedge clk);
        instr_ready = 1'b1;
        applyStimulus(2'd1, 16'd2, 16'd2, 16'd1, 16'd1);
        @(negedge clk);
        rd_we = 1'b1; rd_waddr = TB_RD_REG; rd_wdata = 32'h00000077;
        @(negedge clk);
        rd_we = 1'b0; rdo_ready = 1'b0;
        #1;
        checkOutput("push rdo_data", rdo_data, 32'h00000077);
        checkOutput("push rdo_valid", {31'd0, rdo_valid}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst busy/rdo_valid/cmd_ready", {29'd0, busy, rdo_valid, cmd_ready}, 32'd1);
        checkOutput("rst rdo_data", rdo_data, 32'd0);
        checkOutput("rst stat_word", stat_word, 32'd0);

        @(negedge clk);
        fires0 = fireCount;
        applyStimulus(2'd2, 16'd0, 16'd0, 16'd0, 16'd0);
        @(negedge clk);
        rd_we = 1'b1; rd_waddr = TB_RD_REG; rd_wdata = 32'h0000005A;
        @(negedge clk);
        rd_we = 1'b0;
        #1;
        checkOutput("post-rst stat done/err", {30'd0, done, err}, 32'd2);
        checkOutput("post-rst stat_word", stat_word, 32'h0000005A);
        checkOutput("post-rst fire count", fireCount - fires0, 32'd1);

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
